d_bch_co_reader: RTL and testbench

- Read side of the per-lane chunk buffer that the syndrome stage fills.
- Once error locations for a chunk are known, it streams the buffered bytes back out of the BRAMs and XOR-corrects the flagged bits.
- Multi lanes run in lockstep under one controller, with one shared ready/valid output stream.
- Sits between the buffer BRAMs / Chien-search error reporter and the downstream data path.

---
 rtl/d_bch_co_reader.sv | 185 ++++++++++++++++++
 tb/tb_d_bch_co_reader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/d_bch_co_reader.sv
// Read side of the BCH chunk buffer: streams each lane's buffered bytes out of its BRAM,
// XOR-corrects the bytes flagged by the Chien-search error FIFO, and presents all lanes as one beat.
module d_bch_co_reader #(
  parameter int Multi       = 2,
  parameter int CHUNK_BYTES = 256,
  parameter int ERR_DEPTH   = 32
) (
  input  logic                 i_clk,
  input  logic                 i_RESET,
  input  logic [Multi-1:0]     i_err_valid,
  input  logic [8*Multi-1:0]   i_err_addr,
  input  logic [8*Multi-1:0]   i_err_mask,
  input  logic [Multi-1:0]     i_uncorrectable,
  input  logic                 i_exe_rd,
  output logic                 o_rd_available,
  output logic [Multi-1:0]     o_BRAM_read_enable,
  output logic [8*Multi-1:0]   o_BRAM_read_address,
  input  logic [8*Multi-1:0]   i_BRAM_read_data,
  output logic                 o_data_valid,
  output logic [8*Multi-1:0]   o_data,
  output logic                 o_data_last,
  input  logic                 i_data_ready,
  output logic                 o_rd_cmplt,
  output logic [Multi-1:0]     o_fail,
  output logic [Multi-1:0]     o_err_ovf
);

  localparam int          PW        = $clog2(ERR_DEPTH);
  localparam logic [7:0]  LAST_ADDR = 8'(CHUNK_BYTES - 1);
  localparam logic [PW:0] FIFO_FULL = (PW+1)'(ERR_DEPTH);
  localparam logic [PW:0] ONE       = (PW+1)'(1);
  localparam logic [PW:0] TWO       = (PW+1)'(2);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] mask;
  } err_entry_t;

  state_t     state, state_nxt;
  logic [7:0] addr_cnt, pend_addr;
  logic       rd_pend, issue, pop, start, beat_valid, last_now;
  logic [1:0] skid_cnt;
  logic       skid_wr, skid_rd;
  logic [1:0] skid_last;

  assign start      = (state == IDLE) && i_exe_rd;
  assign beat_valid = (skid_cnt != 2'd0);
  assign last_now   = skid_last[skid_rd];
  assign pop        = beat_valid && i_data_ready;

  // A beat leaving this cycle frees its slot, so the next read can issue without a bubble.
  always_comb begin
    issue = (state == READ) &&
            (({1'b0, skid_cnt} + {2'b00, rd_pend} - {2'b00, pop}) < 3'd2);
  end

  // NOTE: state and counters use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_RESET) begin
    if (!i_RESET) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_exe_rd) state_nxt = READ;
      READ:    if (issue && addr_cnt == LAST_ADDR) state_nxt = DRAIN;
      DRAIN:   if (pop && last_now) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_rd_available      = (state == IDLE);
    o_rd_cmplt          = (state == DONE);
    o_BRAM_read_enable  = {Multi{issue}};
    o_BRAM_read_address = {Multi{addr_cnt}};
    o_data_valid        = beat_valid;
    o_data_last         = beat_valid && last_now;
  end

  always_ff @(posedge i_clk or negedge i_RESET) begin
    if (!i_RESET) begin
      addr_cnt  <= 8'd0;
      pend_addr <= 8'd0;
      rd_pend   <= 1'b0;
      skid_cnt  <= 2'd0;
      skid_wr   <= 1'b0;
      skid_rd   <= 1'b0;
      skid_last <= 2'b00;
    end else begin
      rd_pend <= issue;
      if (start)      addr_cnt <= 8'd0;
      else if (issue) addr_cnt <= addr_cnt + 8'd1;
      if (issue) pend_addr <= addr_cnt;
      if (rd_pend) begin
        skid_last[skid_wr] <= (pend_addr == LAST_ADDR);
        skid_wr            <= ~skid_wr;
      end
      if (pop) skid_rd <= ~skid_rd;
      skid_cnt <= skid_cnt + {1'b0, rd_pend} - {1'b0, pop};
    end
  end

  for (genvar g = 0; g < Multi; g++) begin : g_lane
    err_entry_t fifo_mem [ERR_DEPTH];
    err_entry_t head0, head1;
    logic [PW:0] wr_ptr, rd_ptr, fill, pop_n;
    logic        push, apply, discard, fail_q, ovf_q;
    logic [7:0]  mask_sel, corr;
    logic [7:0]  skid_q [2];

    assign fill  = wr_ptr - rd_ptr;
    assign head0 = fifo_mem[rd_ptr[PW-1:0]];
    assign head1 = fifo_mem[rd_ptr[PW-1:0] + PW'(1)];
    assign push  = (state == IDLE) && i_err_valid[g] && (fill != FIFO_FULL);

    // Stale heads (address already passed) are dropped; the entry behind one can still match.
    always_comb begin
      pop_n    = '0;
      apply    = 1'b0;
      discard  = 1'b0;
      mask_sel = head0.mask;
      if (rd_pend && fill != '0) begin
        if (head0.addr < pend_addr) begin
          discard = 1'b1;
          pop_n   = ONE;
          if (fill >= TWO) begin
            if (head1.addr == pend_addr) begin
              apply    = 1'b1;
              mask_sel = head1.mask;
              pop_n    = TWO;
            end else if (head1.addr < pend_addr) begin
              pop_n = TWO;
            end
          end
        end else if (head0.addr == pend_addr) begin
          apply = 1'b1;
          pop_n = ONE;
        end
      end
      corr = i_BRAM_read_data[8*g +: 8] ^ ((apply && !fail_q) ? mask_sel : 8'h00);
    end

    // NOTE: FIFO storage has no reset; the pointers alone define which entries are live.
    always_ff @(posedge i_clk) begin
      if (push) fifo_mem[wr_ptr[PW-1:0]] <= {i_err_addr[8*g +: 8], i_err_mask[8*g +: 8]};
    end

    always_ff @(posedge i_clk or negedge i_RESET) begin
      if (!i_RESET) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        fail_q <= 1'b0;
        ovf_q  <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + ONE;
        if (state == DONE) rd_ptr <= wr_ptr;
        else               rd_ptr <= rd_ptr + pop_n;
        if (start) fail_q <= i_uncorrectable[g];
        if (start)
          ovf_q <= 1'b0;
        else if (discard || (state == IDLE && i_err_valid[g] && !push))
          ovf_q <= 1'b1;
      end
    end

    always_ff @(posedge i_clk or negedge i_RESET) begin
      if (!i_RESET) begin
        skid_q[0] <= 8'h00;
        skid_q[1] <= 8'h00;
      end else if (rd_pend) begin
        skid_q[skid_wr] <= corr;
      end
    end

    assign o_data[8*g +: 8] = skid_q[skid_rd];
    assign o_fail[g]        = fail_q;
    assign o_err_ovf[g]     = ovf_q;
  end

endmodule

// File: tb/tb_d_bch_co_reader.sv
// Directed bench for d_bch_co_reader: two lanes, 256-byte chunks, hand-derived corrected bytes.
module tb_d_bch_co_reader;

  localparam int LANES = 2;
  localparam int CB    = 256;
  localparam int DEPTH = 32;

  logic              clk, rst;
  logic [LANES-1:0]  err_valid, uncorrectable, bram_en, fail, err_ovf;
  logic [15:0]       err_addr, err_mask, bram_addr, bram_rdata, data;
  logic              exe_rd, rd_available, data_valid, data_last, data_ready, rd_cmplt;

  d_bch_co_reader #(.Multi(LANES), .CHUNK_BYTES(CB), .ERR_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_RESET(rst),
    .i_err_valid(err_valid), .i_err_addr(err_addr), .i_err_mask(err_mask),
    .i_uncorrectable(uncorrectable), .i_exe_rd(exe_rd),
    .o_rd_available(rd_available),
    .o_BRAM_read_enable(bram_en), .o_BRAM_read_address(bram_addr),
    .i_BRAM_read_data(bram_rdata),
    .o_data_valid(data_valid), .o_data(data), .o_data_last(data_last),
    .i_data_ready(data_ready), .o_rd_cmplt(rd_cmplt),
    .o_fail(fail), .o_err_ovf(err_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] bram0 [CB];
  logic [7:0] bram1 [CB];
  always @(posedge clk) begin
    if (bram_en[0]) bram_rdata[7:0]  <= bram0[bram_addr[7:0]];
    if (bram_en[1]) bram_rdata[15:8] <= bram1[bram_addr[15:8]];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0] cap0 [CB];
  logic [7:0] cap1 [CB];
  logic [7:0] exp0 [CB];
  logic [7:0] exp1 [CB];
  int nbeats, nlast, last_idx, first_cyc, last_cyc, cmplt_cyc, cmplt_cnt;
  int stall_err, gap_cnt, max_out, addr_err, timed_out;
  logic avail_busy;

  task automatic raw_expect();
    for (int a = 0; a < CB; a++) begin
      exp0[a] = 8'(a);
      exp1[a] = ~8'(a);
    end
  endtask

  task automatic push(input int lane, input logic [7:0] a, input logic [7:0] m);
    @(negedge clk);
    err_valid            = '0;
    err_valid[lane]      = 1'b1;
    err_addr[8*lane +: 8] = a;
    err_mask[8*lane +: 8] = m;
    @(negedge clk);
    err_valid = '0;
  endtask

  task automatic run_chunk(input bit rand_ready, input logic [1:0] uncorr, input int abort_at);
    int issued = 0;
    bit done = 1'b0;
    logic pv = 1'b0, pr = 1'b0;
    logic [15:0] pd = '0;
    nbeats = 0; nlast = 0; last_idx = -1; first_cyc = -1; last_cyc = -1;
    cmplt_cyc = -1; cmplt_cnt = 0; stall_err = 0; gap_cnt = 0; max_out = 0; addr_err = 0;
    avail_busy = 1'b1;
    @(negedge clk);
    exe_rd = 1'b1; uncorrectable = uncorr;
    @(negedge clk);
    exe_rd = 1'b0; uncorrectable = '0;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      data_ready = rand_ready ? ($urandom_range(0, 9) >= 3) : 1'b1;
      #1;
      if (cyc == 0) avail_busy = rd_available;
      if (pv && !pr && (!data_valid || data !== pd)) stall_err++;
      if (bram_en != '0) begin
        if (bram_en != 2'b11 || bram_addr[7:0] != 8'(issued) || bram_addr[15:8] != bram_addr[7:0])
          addr_err++;
        issued++;
      end
      if (data_valid && first_cyc < 0) first_cyc = cyc;
      if (!rand_ready && first_cyc >= 0 && nbeats < CB && !data_valid) gap_cnt++;
      if (data_valid && data_ready) begin
        if (nbeats < CB) begin
          cap0[nbeats] = data[7:0];
          cap1[nbeats] = data[15:8];
        end
        if (data_last) begin
          nlast++;
          last_idx = nbeats;
          last_cyc = cyc;
        end
        nbeats++;
      end
      if (issued - nbeats > max_out) max_out = issued - nbeats;
      if (rd_cmplt) begin
        cmplt_cnt++;
        if (cmplt_cyc < 0) cmplt_cyc = cyc;
      end
      if (abort_at >= 0 && nbeats == abort_at) begin
        rst  = 1'b0;
        done = 1'b1;
      end
      if (cmplt_cyc >= 0 && cyc >= cmplt_cyc + 3) done = 1'b1;
      pv = data_valid; pr = data_ready; pd = data;
      @(negedge clk);
    end
    timed_out = done ? 0 : 1;
    data_ready = 1'b1;
  endtask

  task automatic verify_chunk(input string tag);
    int mism = 0;
    for (int a = 0; a < CB; a++)
      if (cap0[a] !== exp0[a] || cap1[a] !== exp1[a]) mism++;
    check({tag, "_timeout"}, 32'(timed_out), 32'd0);
    check({tag, "_beats"}, 32'(nbeats), 32'(CB));
    check({tag, "_byte_mismatches"}, 32'(mism), 32'd0);
    check({tag, "_last_count"}, 32'(nlast), 32'd1);
    check({tag, "_last_index"}, 32'(last_idx), 32'(CB - 1));
    check({tag, "_cmplt_delay"}, 32'(cmplt_cyc - last_cyc), 32'd1);
    check({tag, "_cmplt_width"}, 32'(cmplt_cnt), 32'd1);
    check({tag, "_stall_stable"}, 32'(stall_err), 32'd0);
    check({tag, "_rd_addr_seq"}, 32'(addr_err), 32'd0);
    check({tag, "_outstanding_le2"}, 32'(max_out <= 2), 32'd1);
    check({tag, "_avail_busy"}, 32'(avail_busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_avail"}, 32'(rd_available), 32'd1);
    check({tag, "_valid"}, 32'(data_valid), 32'd0);
    check({tag, "_last"}, 32'(data_last), 32'd0);
    check({tag, "_cmplt"}, 32'(rd_cmplt), 32'd0);
    check({tag, "_bram_en"}, 32'(bram_en), 32'd0);
    check({tag, "_bram_addr"}, 32'(bram_addr), 32'd0);
    check({tag, "_data"}, 32'(data), 32'd0);
    check({tag, "_fail"}, 32'(fail), 32'd0);
    check({tag, "_ovf"}, 32'(err_ovf), 32'd0);
  endtask

  initial begin
    int late_cmplt;
    for (int a = 0; a < CB; a++) begin
      bram0[a] = 8'(a);
      bram1[a] = ~8'(a);
    end
    rst = 1'b0; err_valid = '0; err_addr = '0; err_mask = '0;
    uncorrectable = '0; exe_rd = 1'b0; data_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b1;
    @(negedge clk);

    // Clean chunk, ready held high: lane0 = A, lane1 = ~A, no bubbles.
    raw_expect();
    run_chunk(1'b0, 2'b00, -1);
    verify_chunk("raw");
    check("raw_first_beat_cyc", 32'(first_cyc), 32'd2);
    check("raw_gaps", 32'(gap_cnt), 32'd0);
    check("raw_avail_after", 32'(rd_available), 32'd1);

    // Flagged bytes: 3^01=02, 200(C8)^80=48, lane1 byte0 FF^FF=00.
    push(0, 8'd3, 8'h01);
    push(0, 8'd200, 8'h80);
    push(1, 8'd0, 8'hFF);
    raw_expect();
    exp0[3] = 8'h02; exp0[200] = 8'h48; exp1[0] = 8'h00;
    run_chunk(1'b0, 2'b00, -1);
    verify_chunk("corr");
    check("corr_l0_b3", 32'(cap0[3]), 32'h02);
    check("corr_l0_b200", 32'(cap0[200]), 32'h48);
    check("corr_l1_b0", 32'(cap1[0]), 32'h00);
    check("corr_ovf", 32'(err_ovf), 32'd0);

    // Random back-pressure must not change the byte sequence.
    raw_expect();
    run_chunk(1'b1, 2'b00, -1);
    verify_chunk("rand");

    // Lane0 marked uncorrectable: its mask is ignored; lane1 byte5 FA^F0=0A.
    push(0, 8'd5, 8'h0F);
    push(1, 8'd5, 8'hF0);
    raw_expect();
    exp1[5] = 8'h0A;
    run_chunk(1'b0, 2'b01, -1);
    verify_chunk("unc");
    check("unc_l0_b5_raw", 32'(cap0[5]), 32'h05);
    check("unc_l1_b5", 32'(cap1[5]), 32'h0A);
    check("unc_fail", 32'(fail), 32'd1);
    repeat (5) @(negedge clk);
    check("unc_fail_held", 32'(fail), 32'd1);

    // Overflow: 33 pushes on lane0 (entry 32 dropped); lane1 gets 10 then 9 out of order.
    for (int i = 0; i < 33; i++) push(0, 8'(i), 8'h01);
    check("ovf_after_push", 32'(err_ovf), 32'b01);
    push(1, 8'd10, 8'h0F);
    push(1, 8'd9, 8'hFF);
    raw_expect();
    for (int i = 0; i < 32; i++) exp0[i] = exp0[i] ^ 8'h01;
    exp1[10] = 8'hFA;
    run_chunk(1'b0, 2'b00, -1);
    verify_chunk("ovf");
    check("ovf_fail_cleared", 32'(fail), 32'd0);
    check("ovf_l0_b32_dropped", 32'(cap0[32]), 32'h20);
    check("ovf_l0_b31", 32'(cap0[31]), 32'h1E);
    check("ovf_l1_b9_unapplied", 32'(cap1[9]), 32'hF6);
    check("ovf_l1_b10", 32'(cap1[10]), 32'hFA);
    check("ovf_flags_after", 32'(err_ovf), 32'b10);

    // Reset at beat 100 abandons the chunk; the next one starts from address 0.
    push(0, 8'd7, 8'h80);
    raw_expect();
    run_chunk(1'b0, 2'b01, 100);
    check("abort_cmplt_before", 32'(cmplt_cnt), 32'd0);
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    rst = 1'b1;
    late_cmplt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rd_cmplt) late_cmplt++;
    end
    check("abort_no_cmplt", 32'(late_cmplt), 32'd0);
    raw_expect();
    run_chunk(1'b0, 2'b00, -1);
    verify_chunk("post_rst");
    check("post_rst_l0_b7_raw", 32'(cap0[7]), 32'h07);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
